// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/MEM port arbiter for a single-ported fixed-latency unified memory
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              dm_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t            state, state_nx;
    logic              owner_dm;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [3:0]        cnt;
    logic [SW-1:0]     starve_cnt;
    logic              starve_hit;
    logic              grant_dm;
    logic              grant_if;

    // A pending fetch overrides data priority once data has won STARVE_MAX times in a row
    assign starve_hit = if_req && (starve_cnt == SMAX);
    assign grant_dm   = (state == S_IDLE) && dm_req && !starve_hit;
    assign grant_if   = (state == S_IDLE) && !grant_dm && if_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (grant_dm || grant_if) state_nx = S_ISSUE;
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT:  if (cnt == 4'd1) state_nx = S_RESP;
            S_RESP:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_dm   <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            cnt        <= '0;
            starve_cnt <= '0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_dm) begin
                        owner_dm  <= 1'b1;
                        lat_we    <= dm_we;
                        lat_addr  <= dm_addr;
                        lat_wdata <= dm_wdata;
                        if (!if_req)                 starve_cnt <= '0;
                        else if (starve_cnt != SMAX) starve_cnt <= starve_cnt + SW'(1);
                    end else if (grant_if) begin
                        owner_dm   <= 1'b0;
                        lat_we     <= 1'b0;
                        lat_addr   <= if_addr;
                        starve_cnt <= '0;
                    end
                end
                S_ISSUE: cnt <= 4'(MEM_LAT);
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    // Stores never touch the read-data registers
                    if (cnt == 4'd1 && !lat_we) begin
                        if (owner_dm) dm_rdata <= mem_rdata;
                        else          if_rdata <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_en    = (state == S_ISSUE);
    assign mem_we    = (state == S_ISSUE) && lat_we;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign if_valid  = (state == S_RESP) && !owner_dm;
    assign dm_valid  = (state == S_RESP) && owner_dm;
    assign if_stall  = if_req && !if_valid;
    assign dm_stall  = dm_req && !dm_valid;

endmodule
